// File: rtl/saat_uart_raporlayici_pkg.sv
// Shared types and constants for the clock report transmitter: FSM states,
// ASCII codes, line lengths and small digit-to-ASCII helpers.
package saat_paket;

  typedef enum logic [1:0] {
    BOSTA   = 2'd0,
    GONDER  = 2'd1,
    BASLADI = 2'd2,
    BEKLE   = 2'd3
  } durum_t;

  localparam logic [7:0] ASCII_SIFIR     = 8'h30;
  localparam logic [7:0] ASCII_IKI_NOKTA = 8'h3A;
  localparam logic [7:0] ASCII_NOKTA     = 8'h2E;
  localparam logic [7:0] ASCII_BOSLUK    = 8'h20;
  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_LF        = 8'h0A;

  localparam int SAAT_UZ_CRLF  = 10;
  localparam int SAAT_UZ_LF    = 9;
  localparam int TARIH_UZ_CRLF = 21;
  localparam int TARIH_UZ_LF   = 20;
  // "DD.MM.YYYY " precedes the time part when the date prefix is built in
  localparam int TARIH_OFSET   = 11;

  function automatic logic [7:0] onlar_ascii(input logic [5:0] v);
    return ASCII_SIFIR + 8'(v / 6'd10);
  endfunction

  function automatic logic [7:0] birler_ascii(input logic [5:0] v);
    return ASCII_SIFIR + 8'(v % 6'd10);
  endfunction

  function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
    return ASCII_SIFIR + {4'd0, d};
  endfunction

endpackage

// File: rtl/saat_uart_raporlayici_ikili_bcd.sv
// Combinational 12-bit binary to 4-digit BCD converter (double-dabble).
module ikili_bcd (
  input  logic [11:0] i_ikili,
  output logic [15:0] o_bcd
);

  logic [27:0] w_kaydir;

  always_comb begin
    w_kaydir = {16'd0, i_ikili};
    for (int i = 0; i < 12; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (w_kaydir[12 + 4*d +: 4] >= 4'd5)
          w_kaydir[12 + 4*d +: 4] = w_kaydir[12 + 4*d +: 4] + 4'd3;
      end
      w_kaydir = w_kaydir << 1;
    end
  end

  assign o_bcd = w_kaydir[27:12];

endmodule

// File: rtl/saat_uart_raporlayici.sv
// Freezes the time on request and streams it as an ASCII line to uart_tx.
// Define TARIH_RAPOR_EN to prefix the line with "DD.MM.YYYY ".
module saat_uart_raporlayici
  import saat_paket::*;
#(
  parameter bit SATIR_SONU_CRLF = 1'b1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        istek,
  input  logic [4:0]  saat,
  input  logic [5:0]  dakika,
  input  logic [5:0]  saniye,
  input  logic [4:0]  gun,
  input  logic [3:0]  ay,
  input  logic [11:0] yil,
  input  logic        uart_tx_busy,
  output logic        uart_tx_en,
  output logic [7:0]  uart_tx_data,
  output logic        mesgul,
  output logic        bitti,
  output logic [1:0]  durum
);

`ifdef TARIH_RAPOR_EN
  localparam int MESAJ_UZ = SATIR_SONU_CRLF ? TARIH_UZ_CRLF : TARIH_UZ_LF;
`else
  localparam int MESAJ_UZ = SATIR_SONU_CRLF ? SAAT_UZ_CRLF : SAAT_UZ_LF;
`endif
  localparam logic [4:0] SON_INDEKS = 5'(MESAJ_UZ - 1);

  // Handshake with uart_tx: a byte is offered by a single-cycle uart_tx_en only
  // while uart_tx_busy is low; the byte counts as accepted once busy has risen
  // and is complete once busy falls again. uart_tx_data holds until the next strobe.
  durum_t      r_durum, w_durum_sonraki;
  logic [4:0]  r_indeks, w_indeks_sonraki, w_zaman_idx;
  logic [4:0]  r_saat;
  logic [5:0]  r_dakika, r_saniye;
  logic        w_en_sonraki, w_mesgul_sonraki, w_bitti_sonraki, w_son_bayt, w_yakala;
  logic [7:0]  w_veri_sonraki, w_zaman_kar, w_karakter;

  assign w_son_bayt = (r_indeks == SON_INDEKS);
  assign w_yakala   = (r_durum == BOSTA) && istek;
  assign durum      = r_durum;

  always_comb begin
    w_zaman_kar = ASCII_LF;
    case (w_zaman_idx)
      5'd0:    w_zaman_kar = onlar_ascii({1'b0, r_saat});
      5'd1:    w_zaman_kar = birler_ascii({1'b0, r_saat});
      5'd2:    w_zaman_kar = ASCII_IKI_NOKTA;
      5'd3:    w_zaman_kar = onlar_ascii(r_dakika);
      5'd4:    w_zaman_kar = birler_ascii(r_dakika);
      5'd5:    w_zaman_kar = ASCII_IKI_NOKTA;
      5'd6:    w_zaman_kar = onlar_ascii(r_saniye);
      5'd7:    w_zaman_kar = birler_ascii(r_saniye);
      5'd8:    w_zaman_kar = SATIR_SONU_CRLF ? ASCII_CR : ASCII_LF;
      default: w_zaman_kar = ASCII_LF;
    endcase
  end

`ifdef TARIH_RAPOR_EN
  logic [4:0]  r_gun;
  logic [3:0]  r_ay;
  logic [11:0] r_yil;
  logic [15:0] w_yil_bcd;

  ikili_bcd u_yil_bcd (
    .i_ikili (r_yil),
    .o_bcd   (w_yil_bcd)
  );

  assign w_zaman_idx = r_indeks - 5'(TARIH_OFSET);

  always_comb begin
    w_karakter = w_zaman_kar;
    if (r_indeks < 5'(TARIH_OFSET)) begin
      case (r_indeks)
        5'd0:    w_karakter = onlar_ascii({1'b0, r_gun});
        5'd1:    w_karakter = birler_ascii({1'b0, r_gun});
        5'd2:    w_karakter = ASCII_NOKTA;
        5'd3:    w_karakter = onlar_ascii({2'b00, r_ay});
        5'd4:    w_karakter = birler_ascii({2'b00, r_ay});
        5'd5:    w_karakter = ASCII_NOKTA;
        5'd6:    w_karakter = bcd_ascii(w_yil_bcd[15:12]);
        5'd7:    w_karakter = bcd_ascii(w_yil_bcd[11:8]);
        5'd8:    w_karakter = bcd_ascii(w_yil_bcd[7:4]);
        5'd9:    w_karakter = bcd_ascii(w_yil_bcd[3:0]);
        default: w_karakter = ASCII_BOSLUK;
      endcase
    end
  end
`else
  logic w_unused_tarih;
  assign w_unused_tarih = ^{gun, ay, yil};
  assign w_zaman_idx    = r_indeks;
  assign w_karakter     = w_zaman_kar;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_durum      <= BOSTA;
      r_indeks     <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
      mesgul       <= 1'b0;
      bitti        <= 1'b0;
      r_saat       <= '0;
      r_dakika     <= '0;
      r_saniye     <= '0;
`ifdef TARIH_RAPOR_EN
      r_gun        <= '0;
      r_ay         <= '0;
      r_yil        <= '0;
`endif
    end else begin
      r_durum      <= w_durum_sonraki;
      r_indeks     <= w_indeks_sonraki;
      uart_tx_en   <= w_en_sonraki;
      uart_tx_data <= w_veri_sonraki;
      mesgul       <= w_mesgul_sonraki;
      bitti        <= w_bitti_sonraki;
      if (w_yakala) begin
        r_saat   <= saat;
        r_dakika <= dakika;
        r_saniye <= saniye;
`ifdef TARIH_RAPOR_EN
        r_gun    <= gun;
        r_ay     <= ay;
        r_yil    <= yil;
`endif
      end
    end
  end

  always_comb begin
    w_durum_sonraki = r_durum;
    case (r_durum)
      BOSTA:   if (istek)         w_durum_sonraki = GONDER;
      GONDER:  if (!uart_tx_busy) w_durum_sonraki = BASLADI;
      BASLADI: if (uart_tx_busy)  w_durum_sonraki = BEKLE;
      BEKLE:   if (!uart_tx_busy) w_durum_sonraki = w_son_bayt ? BOSTA : GONDER;
      default:                    w_durum_sonraki = BOSTA;
    endcase
  end

  always_comb begin
    w_en_sonraki     = 1'b0;
    w_veri_sonraki   = uart_tx_data;
    w_mesgul_sonraki = mesgul;
    w_bitti_sonraki  = 1'b0;
    w_indeks_sonraki = r_indeks;
    case (r_durum)
      BOSTA: begin
        if (istek) begin
          w_mesgul_sonraki = 1'b1;
          w_indeks_sonraki = '0;
        end
      end
      GONDER: begin
        if (!uart_tx_busy) begin
          w_en_sonraki   = 1'b1;
          w_veri_sonraki = w_karakter;
        end
      end
      BEKLE: begin
        if (!uart_tx_busy) begin
          if (w_son_bayt) begin
            w_bitti_sonraki  = 1'b1;
            w_mesgul_sonraki = 1'b0;
          end else begin
            w_indeks_sonraki = r_indeks + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
